// File: rtl/mp_arith_seq_if.sv
// ---------------------------------------------------------------------------
// mp_arith_seq_if
// Bundles every signal of the multi-precision sequencer apart from clk/rst.
// Two groups of signals share the bundle:
//   - control side: start, op, opa, opb in; busy, done, result, carry_out,
//     zero, err out
//   - alu side: alu_instr, alu_a, alu_b, alu_c_in, alu_b_in out;
//     alu_res, alu_c_out, alu_b_out, alu_flag_valid in
// Modports:
//   slave  - used by the sequencer itself
//   master - used by whatever sits around it (control unit plus alu, or a bench)
// ---------------------------------------------------------------------------
interface mp_arith_seq_if #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 4,
  parameter int WORDS  = 4
);
  logic                     start;
  logic [1:0]               op;
  logic [WORDS*WIDTH-1:0]   opa;
  logic [WORDS*WIDTH-1:0]   opb;
  logic                     busy;
  logic                     done;
  logic [WORDS*WIDTH-1:0]   result;
  logic                     carry_out;
  logic                     zero;
  logic                     err;
  logic [IWIDTH-1:0]        alu_instr;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic                     alu_c_in;
  logic                     alu_b_in;
  logic [WIDTH-1:0]         alu_res;
  logic                     alu_c_out;
  logic                     alu_b_out;
  logic                     alu_flag_valid;

  modport slave (
    input  start, op, opa, opb,
    input  alu_res, alu_c_out, alu_b_out, alu_flag_valid,
    output busy, done, result, carry_out, zero, err,
    output alu_instr, alu_a, alu_b, alu_c_in, alu_b_in
  );

  modport master (
    output start, op, opa, opb,
    output alu_res, alu_c_out, alu_b_out, alu_flag_valid,
    input  busy, done, result, carry_out, zero, err,
    input  alu_instr, alu_a, alu_b, alu_c_in, alu_b_in
  );
endinterface

// File: rtl/mp_arith_seq.sv
// ---------------------------------------------------------------------------
// mp_arith_seq
// Multi-precision arithmetic sequencer placed in front of a WIDTH-bit alu.
// Runs ADD / SUB / INC / DEC on WORDS*WIDTH-bit operands by handing the alu
// one WIDTH-bit slice per cycle, LSB slice first, chaining carry or borrow
// from one slice into the next and collecting each result slice.
// Ports:
//   clk  - single clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mp_arith_seq_if.slave
//          control side: start/op/opa/opb in; busy/done/result/carry_out/
//                        zero/err out
//          alu side:     alu_instr/alu_a/alu_b/alu_c_in/alu_b_in out;
//                        alu_res/alu_c_out/alu_b_out/alu_flag_valid in
// op encoding: 00 ADD, 01 SUB, 10 INC (opa+1), 11 DEC (opa-1).
// ---------------------------------------------------------------------------
module mp_arith_seq #(
  parameter int                WIDTH   = 8,
  parameter int                IWIDTH  = 4,
  parameter int                WORDS   = 4,
  parameter logic [IWIDTH-1:0] ALU_NOP = IWIDTH'(0),
  parameter logic [IWIDTH-1:0] ALU_ADD = IWIDTH'(1),
  parameter logic [IWIDTH-1:0] ALU_SUB = IWIDTH'(2),
  parameter logic [IWIDTH-1:0] ALU_INC = IWIDTH'(3),
  parameter logic [IWIDTH-1:0] ALU_DEC = IWIDTH'(4)
) (
  input  logic          clk,
  input  logic          rst,
  mp_arith_seq_if.slave bus
);

  localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                        r_state;
  logic [1:0]                    r_op;
  logic [WORDS-1:0][WIDTH-1:0]   r_opa;
  logic [WORDS-1:0][WIDTH-1:0]   r_opb;
  logic [WORDS-1:0][WIDTH-1:0]   r_result;
  logic [IDXW-1:0]               r_idx;
  logic                          r_chain;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_carry;
  logic                          r_zero;
  logic                          r_err;

  logic [IWIDTH-1:0]             w_aluInstr;
  logic [WIDTH-1:0]              w_aluA;
  logic [WIDTH-1:0]              w_aluB;
  logic                          w_aluCIn;
  logic                          w_aluBIn;
  logic                          w_chainNext;
  logic [WORDS-1:0][WIDTH-1:0]   w_nextResult;

  // op[0] marks the subtract family (SUB/DEC), op[1] the unary family
  // (INC/DEC). INC/DEC only apply their +1/-1 on slice 0; upper slices
  // are plain ADD/SUB with a zero B operand so the carry/borrow ripples up.
  always_comb begin
    w_aluInstr = ALU_NOP;
    w_aluA     = '0;
    w_aluB     = '0;
    w_aluCIn   = 1'b0;
    w_aluBIn   = 1'b0;
    if (r_state == S_RUN) begin
      w_aluA   = r_opa[r_idx];
      w_aluB   = r_op[1] ? '0 : r_opb[r_idx];
      w_aluCIn = r_op[0] ? 1'b0 : r_chain;
      w_aluBIn = r_op[0] ? r_chain : 1'b0;
      case (r_op)
        OP_ADD:  w_aluInstr = ALU_ADD;
        OP_SUB:  w_aluInstr = ALU_SUB;
        OP_INC:  w_aluInstr = (r_idx == '0) ? ALU_INC : ALU_ADD;
        OP_DEC:  w_aluInstr = (r_idx == '0) ? ALU_DEC : ALU_SUB;
        default: w_aluInstr = ALU_NOP;
      endcase
    end
  end

  // The chain bit follows carry for the add family and borrow for the
  // subtract family. The next result is the current one with the active
  // slice replaced, so the zero flag can be taken from the full word on the
  // same edge that writes the last slice.
  always_comb begin
    w_chainNext         = r_op[0] ? bus.alu_b_out : bus.alu_c_out;
    w_nextResult        = r_result;
    w_nextResult[r_idx] = bus.alu_res;
  end

  // Main sequencer: IDLE/DONE wait for start, RUN walks the slices. err is
  // sticky across operations and only reset clears it. Leaving DONE without
  // a new start drops back to IDLE so done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_chain  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_result <= w_nextResult;
          r_chain  <= w_chainNext;
          if (!bus.alu_flag_valid) begin
            r_err <= 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_carry <= w_chainNext;
            r_zero  <= (w_nextResult == '0);
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_op     <= bus.op;
            r_opa    <= bus.opa;
            r_opb    <= bus.opb;
            r_result <= '0;
            r_idx    <= '0;
            r_chain  <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;
  assign bus.alu_instr = w_aluInstr;
  assign bus.alu_a     = w_aluA;
  assign bus.alu_b     = w_aluB;
  assign bus.alu_c_in  = w_aluCIn;
  assign bus.alu_b_in  = w_aluBIn;

endmodule

// File: tb/tb_mp_arith_seq.sv
// ---------------------------------------------------------------------------
// tb_mp_arith_seq
// Bench for mp_arith_seq with WORDS=4, WIDTH=8. A small behavioural 8-bit
// alu answers the sequencer's slice requests; finished results are compared
// against a whole-word 32-bit arithmetic reference.
// ---------------------------------------------------------------------------
module tb_mp_arith_seq;

  localparam int WIDTH  = 8;
  localparam int IWIDTH = 4;
  localparam int WORDS  = 4;

  localparam logic [IWIDTH-1:0] ALU_NOP = 4'd0;
  localparam logic [IWIDTH-1:0] ALU_ADD = 4'd1;
  localparam logic [IWIDTH-1:0] ALU_SUB = 4'd2;
  localparam logic [IWIDTH-1:0] ALU_INC = 4'd3;
  localparam logic [IWIDTH-1:0] ALU_DEC = 4'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  logic       clk;
  logic       rst;
  logic       aluFlagValid;
  logic [WIDTH:0] aluWide;
  int         vectorCount;
  int         missCount;

  mp_arith_seq_if #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .WORDS(WORDS)) bus ();

  mp_arith_seq #(
    .WIDTH(WIDTH), .IWIDTH(IWIDTH), .WORDS(WORDS),
    .ALU_NOP(ALU_NOP), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB),
    .ALU_INC(ALU_INC), .ALU_DEC(ALU_DEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 8-bit alu: carry out of ADD/INC, borrow out of SUB/DEC.
  always_comb begin
    aluWide       = '0;
    bus.alu_res   = '0;
    bus.alu_c_out = 1'b0;
    bus.alu_b_out = 1'b0;
    case (bus.alu_instr)
      ALU_ADD: begin
        aluWide       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{WIDTH{1'b0}}, bus.alu_c_in};
        bus.alu_res   = aluWide[WIDTH-1:0];
        bus.alu_c_out = aluWide[WIDTH];
      end
      ALU_SUB: begin
        aluWide       = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {{WIDTH{1'b0}}, bus.alu_b_in};
        bus.alu_res   = aluWide[WIDTH-1:0];
        bus.alu_b_out = aluWide[WIDTH];
      end
      ALU_INC: begin
        aluWide       = {1'b0, bus.alu_a} + 9'd1;
        bus.alu_res   = aluWide[WIDTH-1:0];
        bus.alu_c_out = aluWide[WIDTH];
      end
      ALU_DEC: begin
        aluWide       = {1'b0, bus.alu_a} - 9'd1;
        bus.alu_res   = aluWide[WIDTH-1:0];
        bus.alu_b_out = aluWide[WIDTH];
      end
      default: ;
    endcase
  end

  assign bus.alu_flag_valid = aluFlagValid;

  // Whole-word reference: plain 32-bit arithmetic, wrap modulo 2^32.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] res,
                                   output logic cy);
    logic [32:0] wide;
    wide = '0;
    res  = '0;
    cy   = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[31:0];
        cy   = wide[32];
      end
      OP_SUB: begin
        res = a - b;
        cy  = (a < b);
      end
      OP_INC: begin
        res = a + 32'd1;
        cy  = (a == 32'hFFFF_FFFF);
      end
      default: begin
        res = a - 32'd1;
        cy  = (a == 32'd0);
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation: raise start for one edge, wait (bounded) for done,
  // then compare latency, result, carry and zero against the reference.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    logic [31:0] expRes;
    logic        expCy;
    int          n;
    refModel(op, a, b, expRes, expCy);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("busy_on_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", 32'(n), 32'(WORDS));
    checkOutput("result", bus.result, expRes);
    checkOutput("carry_out", 32'(bus.carry_out), 32'(expCy));
    checkOutput("zero", 32'(bus.zero), 32'(expRes == 32'd0));
    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
    checkOutput("nop_at_done", 32'(bus.alu_instr), 32'(ALU_NOP));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expCy;
    logic [1:0]  op;
    int          n;
    int          doneCount;
    int          sel;

    vectorCount  = 0;
    missCount    = 0;
    rst          = 1'b1;
    aluFlagValid = 1'b1;
    bus.start    = 1'b0;
    bus.op       = OP_ADD;
    bus.opa      = '0;
    bus.opb      = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    checkOutput("rst_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("rst_zero", 32'(bus.zero), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_instr", 32'(bus.alu_instr), 32'(ALU_NOP));
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    applyStimulus(OP_ADD, 32'h0000_00FF, 32'h0000_0001);
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(OP_SUB, 32'h0000_0000, 32'h0000_0001);
    applyStimulus(OP_SUB, 32'h0000_1234, 32'h0000_1234);
    applyStimulus(OP_INC, 32'h00FF_FFFF, 32'hDEAD_BEEF);
    applyStimulus(OP_DEC, 32'h0100_0000, 32'h1234_5678);
    applyStimulus(OP_INC, 32'hFFFF_FFFF, 32'h0000_0000);
    applyStimulus(OP_DEC, 32'h0000_0000, 32'hFFFF_FFFF);

    // start pulsed mid-RUN must be ignored and not queued
    refModel(OP_ADD, 32'h1111_2222, 32'h3333_4444, expRes, expCy);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.opa   = 32'h1111_2222;
    bus.opb   = 32'h3333_4444;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_SUB;
    bus.opa   = 32'h0000_0005;
    bus.opb   = 32'h0000_0009;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 2;
    while (!bus.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("midrun_latency", 32'(n), 32'(WORDS));
    checkOutput("midrun_result", bus.result, expRes);
    @(posedge clk);
    #1;
    checkOutput("midrun_no_queue_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrun_no_queue_done", 32'(bus.done), 32'd0);

    // start held through done: two operations back to back, one done each
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.opa   = 32'h0000_0010;
    bus.opb   = 32'h0000_0020;
    doneCount = 0;
    repeat (WORDS + 1) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCount++;
    end
    checkOutput("held_first_result", bus.result, 32'h0000_0030);
    bus.opa = 32'hFFFF_FFF0;
    bus.opb = 32'h0000_0020;
    @(posedge clk);
    #1;
    checkOutput("held_busy_again", 32'(bus.busy), 32'd1);
    checkOutput("held_done_single", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    repeat (WORDS + 3) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        doneCount++;
        checkOutput("held_second_result", bus.result, 32'h0000_0010);
        checkOutput("held_second_carry", 32'(bus.carry_out), 32'd1);
      end
    end
    checkOutput("held_done_count", 32'(doneCount), 32'd2);

    // Reset while slice 2 is in flight
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.opa   = 32'h8765_4321;
    bus.opb   = 32'h1111_1111;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_result", bus.result, 32'd0);
    checkOutput("midrst_instr", 32'(bus.alu_instr), 32'(ALU_NOP));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(OP_ADD, 32'd1, 32'd1);

    // err is sticky once alu_flag_valid drops in RUN, cleared only by reset
    checkOutput("err_clear_before", 32'(bus.err), 32'd0);
    aluFlagValid = 1'b0;
    applyStimulus(OP_SUB, 32'h0000_0100, 32'h0000_0001);
    checkOutput("err_set", 32'(bus.err), 32'd1);
    aluFlagValid = 1'b1;
    applyStimulus(OP_ADD, 32'h0000_0003, 32'h0000_0004);
    checkOutput("err_sticky", 32'(bus.err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("err_rst", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized operations biased towards all-zero / all-one operands
    for (int k = 0; k < 40; k++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      applyStimulus(op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
